// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator sequencer.
//   - sequencer state encoding
//   - default widths / depths and the minimum decimation ratio
package cic_pkg;

  localparam int unsigned RW_DEF     = 8;
  localparam int unsigned DW_DEF     = 10;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned NSTAGE_DEF = 3;

  // Ratios below this are coerced up to it, so comb_en can never fire on
  // two consecutive cycles.
  localparam int unsigned MIN_RATIO  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/cic_out_fifo.sv
// DEPTH x DW first-word-fall-through FIFO for decimated comb outputs.
//   clk, reset (async, active low)
//   i_push/i_din  : write side (caller guarantees push only when !full or popping)
//   i_pop         : read side (caller guarantees pop only when !empty)
//   o_dout        : current head word (registered storage)
//   o_empty/o_full: occupancy flags
module cic_out_fifo #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic          o_empty,
  output logic          o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW + 1)'(DEPTH));

endmodule

// File: rtl/cic_dec_ctrl.sv
// Sequencer for a 3-stage CIC decimator (integrators at input rate, combs at
// decimated rate). Discards the first NSTAGE decimated outputs after start and
// buffers the rest in an output FIFO with a valid/ready handshake.
//   clk, reset (async, active low)
//   cfg_we/cfg_ratio : decimation ratio write (0/1 coerced to 2)
//   run              : level, decimate while high
//   in_valid         : input sample strobe
//   int_en/int_clr   : integrator advance / clear
//   comb_en/comb_clr : comb advance strobe / clear
//   y_in             : comb output, valid the cycle after comb_en
//   out_valid/out_ready/y_out : downstream handshake, FIFO head
//   busy, overrun (sticky drop flag), out_count (delivered-sample counter)
// Optional: define CIC_DEC_CTRL_STATS_EN to enable out_count; otherwise it is 0.
module cic_dec_ctrl
  import cic_pkg::*;
#(
  parameter int unsigned RW     = RW_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned NSTAGE = NSTAGE_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [RW-1:0] cfg_ratio,
  input  logic          run,
  input  logic          in_valid,
  output logic          int_en,
  output logic          int_clr,
  output logic          comb_en,
  output logic          comb_clr,
  input  logic [DW-1:0] y_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y_out,
  output logic          busy,
  output logic          overrun,
  output logic [15:0]   out_count
);

  localparam int unsigned WW = $clog2(NSTAGE + 2);

  state_t        r_state, w_state_nxt;
  logic [RW-1:0] r_ratio_active, r_ratio_shadow, r_phase;
  logic [WW-1:0] r_warm;
  logic          r_capture_pend, r_overrun;

  logic [RW-1:0] w_ratio_cfg;
  logic          w_int_en, w_comb_en, w_flush;
  logic          w_empty, w_full, w_pop, w_push, w_drop, w_keep;

  assign w_ratio_cfg = (cfg_ratio < RW'(MIN_RATIO)) ? RW'(MIN_RATIO) : cfg_ratio;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_int_en    = 1'b0;
    w_comb_en   = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (run) w_state_nxt = ST_FLUSH;
      ST_FLUSH: begin
        w_flush     = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Enables are gated by run so nothing advances in the stopping cycle.
        if (!run) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_int_en  = in_valid;
          w_comb_en = in_valid && (r_phase == r_ratio_active - RW'(1));
        end
      end
      ST_DRAIN: if (!r_capture_pend && w_empty) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture decision: a full FIFO still accepts if the head leaves this cycle.
  assign w_pop  = !w_empty && out_ready;
  assign w_keep = r_capture_pend && (r_warm == '0);
  assign w_push = w_keep && (!w_full || w_pop);
  assign w_drop = w_keep && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ratio_active <= RW'(MIN_RATIO);
      r_ratio_shadow <= RW'(MIN_RATIO);
      r_phase        <= '0;
      r_warm         <= '0;
      r_capture_pend <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (cfg_we) begin
        r_ratio_shadow <= w_ratio_cfg;
        if (r_state == ST_IDLE) r_ratio_active <= w_ratio_cfg;
      end
      if (w_flush) begin
        r_phase <= '0;
        r_warm  <= WW'(NSTAGE);
      end else if (w_int_en) begin
        if (w_comb_en) begin
          r_phase        <= '0;
          r_ratio_active <= r_ratio_shadow;
        end else begin
          r_phase <= r_phase + RW'(1);
        end
      end
      if (r_capture_pend && (r_warm != '0)) r_warm <= r_warm - WW'(1);
      r_capture_pend <= w_comb_en;
      // A drop in the same cycle as a clear leaves the flag set.
      if (cfg_we || w_flush) r_overrun <= 1'b0;
      if (w_drop)            r_overrun <= 1'b1;
    end
  end

  cic_out_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (y_in),
    .i_pop   (w_pop),
    .o_dout  (y_out),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

`ifdef CIC_DEC_CTRL_STATS_EN
  logic [15:0] r_out_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_out_count <= '0;
    else if (w_flush) r_out_count <= '0;
    else if (w_pop) r_out_count <= r_out_count + 16'd1;
  end
  assign out_count = r_out_count;
`else
  assign out_count = '0;
`endif

  assign int_en    = w_int_en;
  assign comb_en   = w_comb_en;
  assign int_clr   = w_flush;
  assign comb_clr  = w_flush;
  assign out_valid = !w_empty;
  assign busy      = (r_state != ST_IDLE);
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Self-checking bench for cic_dec_ctrl: per-cycle reference model with a
// scoreboard queue of expected FIFO words, a table of ratio/pattern vectors,
// and directed sequences for overrun, drain and mid-run reset.
module tb_cic_dec_ctrl;
  localparam int RW = 8, DW = 10, DEPTH = 4, NSTAGE = 3;

  logic          clk = 1'b0, reset = 1'b0;
  logic          cfg_we = 1'b0, run = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [RW-1:0] cfg_ratio = '0;
  logic [DW-1:0] y_in = '0;
  logic          int_en, int_clr, comb_en, comb_clr, out_valid, busy, overrun;
  logic [DW-1:0] y_out;
  logic [15:0]   out_count;

  always #5 clk = ~clk;

  cic_dec_ctrl #(.RW(RW), .DW(DW), .DEPTH(DEPTH), .NSTAGE(NSTAGE)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ratio(cfg_ratio), .run(run),
    .in_valid(in_valid), .int_en(int_en), .int_clr(int_clr), .comb_en(comb_en),
    .comb_clr(comb_clr), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .busy(busy), .overrun(overrun), .out_count(out_count)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state (0 idle, 1 flush, 2 run, 3 drain)
  int            m_st, m_phase, m_ract, m_rsh, m_warm, m_cnt;
  bit            m_cap, m_ovr;
  logic [DW-1:0] q[$];

  task automatic m_reset();
    m_st = 0; m_phase = 0; m_ract = 2; m_rsh = 2; m_warm = 0; m_cnt = 0;
    m_cap = 0; m_ovr = 0; q.delete();
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step(input bit i_run, input bit i_val, input bit i_rdy,
                      input bit i_we, input int i_ratio);
    bit e_int, e_comb, pop, cap_old, emp_old, push_ok;
    int c;
    @(posedge clk); #1;
    run = i_run; in_valid = i_val; out_ready = i_rdy; cfg_we = i_we;
    cfg_ratio = RW'(i_ratio);
    y_in = DW'($urandom_range(0, 1023));
    #1;
    e_int  = (m_st == 2) && i_run && i_val;
    e_comb = e_int && (m_phase == m_ract - 1);
    chk("int_en",    int_en,    e_int);
    chk("comb_en",   comb_en,   e_comb);
    chk("int_clr",   int_clr,   m_st == 1);
    chk("comb_clr",  comb_clr,  m_st == 1);
    chk("busy",      busy,      m_st != 0);
    chk("out_valid", out_valid, q.size() != 0);
    chk("overrun",   overrun,   m_ovr);
    if (q.size() != 0) chk("y_out", y_out, q[0]);
`ifdef CIC_DEC_CTRL_STATS_EN
    chk("out_count", out_count, m_cnt);
`else
    chk("out_count", out_count, 0);
`endif
    cap_old = m_cap; emp_old = (q.size() == 0); push_ok = 0;
    pop = !emp_old && i_rdy;
    if (i_we || m_st == 1) m_ovr = 0;
    if (cap_old) begin
      if (m_warm > 0)                        m_warm--;
      else if (q.size() == DEPTH && !pop)    m_ovr = 1;
      else                                   push_ok = 1;
    end
    if (pop) begin q.delete(0); m_cnt = (m_cnt + 1) & 16'hFFFF; end
    if (push_ok) q.push_back(y_in);
    m_cap = e_comb;
    c = (i_ratio < 2) ? 2 : i_ratio;
    if (e_comb) m_ract = m_rsh;
    if (i_we) begin m_rsh = c; if (m_st == 0) m_ract = c; end
    if (e_int) m_phase = e_comb ? 0 : m_phase + 1;
    case (m_st)
      0: if (i_run) m_st = 1;
      1: begin m_st = 2; m_phase = 0; m_warm = NSTAGE; m_cnt = 0; end
      2: if (!i_run) m_st = 3;
      default: if (!cap_old && emp_old) m_st = 0;
    endcase
  endtask

  task automatic go_idle();
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, 0, 0);
      if (!busy) break;
    end
    chk("go_idle", busy, 0);
  endtask

  typedef struct { int ratio; bit toggle; int gap; } vec_t;
  vec_t vecs[6];

  initial begin
    int t[4];
    int np, tv, s, pops;
    bit done;
    vecs[0] = '{4, 0, 4};
    vecs[1] = '{0, 0, 2};
    vecs[2] = '{1, 0, 2};
    vecs[3] = '{0, 1, 4};
    vecs[4] = '{3, 1, 6};
    vecs[5] = '{8, 0, 8};
    m_reset();

    // Reset state
    #3;
    chk("rst_busy", busy, 0);       chk("rst_out_valid", out_valid, 0);
    chk("rst_int_clr", int_clr, 0); chk("rst_comb_clr", comb_clr, 0);
    chk("rst_overrun", overrun, 0); chk("rst_y_out", y_out, 0);
    chk("rst_out_count", out_count, 0);
    #9 reset = 1'b1;

    // Ratio / input-pattern table: comb_en spacing and warm-up latency
    foreach (vecs[v]) begin
      step(0, 0, 1, 1, vecs[v].ratio);
      for (int i = 0; i < 4; i++) t[i] = -100;
      np = 0; tv = -1;
      for (int k = 0; k < 4 * vecs[v].gap + 6; k++) begin
        step(1, vecs[v].toggle ? (k % 2 == 0) : 1'b1, 1, 0, 0);
        if (comb_en && np < 4) begin t[np] = k; np++; end
        if (out_valid && tv < 0) tv = k;
      end
      chk("vec_gap1", t[1] - t[0], vecs[v].gap);
      chk("vec_gap2", t[2] - t[1], vecs[v].gap);
      chk("vec_latency", tv, t[3] + 2);
      go_idle();
    end

    // Ratio change mid-run: current interval completes, next uses new ratio
    step(0, 0, 1, 1, 4);
    s = -1;
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 1, 0, 0);
      if (comb_en) begin s = k; break; end
    end
    chk("mr_first_comb", s >= 0, 1);
    np = 0; t[0] = -100; t[1] = -100;
    for (int k = 1; k < 30; k++) begin
      step(1, 1, 1, k == 1, 8);
      if (comb_en && np < 2) begin t[np] = k; np++; end
    end
    chk("mr_gap_old", t[0], 4);
    chk("mr_gap_new", t[1] - t[0], 8);
    go_idle();

    // Overrun with ready low, then full push+pop without drop
    step(0, 0, 1, 1, 2);
    for (int k = 0; k < 22; k++) step(1, 1, 0, 0, 0);
    chk("ovr_set", overrun, 1);
    chk("ovr_full_valid", out_valid, 1);
    for (int k = 0; k < 10; k++) step(1, 1, m_cap, k == 0, 2);
    chk("ovr_pushpop_clear", overrun, 0);
    chk("ovr_pushpop_valid", out_valid, 1);
    go_idle();

    // Stop with 3 words buffered and a capture pending: drain delivers 4
    step(0, 0, 1, 1, 2);
    done = 0;
    for (int k = 0; k < 30; k++) begin
      if (q.size() == 3 && m_cap) begin step(0, 1, 0, 0, 0); done = 1; break; end
      step(1, 1, 0, 0, 0);
    end
    chk("drain_setup", done, 1);
    step(0, 0, 1, 0, 0);
    chk("drain_busy", busy, 1);
    pops = out_valid ? 1 : 0;
    for (int k = 0; k < 20 && busy; k++) begin
      step(0, 0, 1, 0, 0);
      if (out_valid) pops++;
    end
    chk("drain_pops", pops, 4);
    chk("drain_idle", busy, 0);
`ifdef CIC_DEC_CTRL_STATS_EN
    chk("stats_count", out_count, 4);
`endif

    // Asynchronous reset in the middle of RUN with data buffered
    step(0, 0, 1, 1, 2);
    for (int k = 0; k < 14; k++) step(1, 1, 0, 0, 0);
    chk("pre_rst_valid", out_valid, 1);
    #1 reset = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);       chk("mrst_out_valid", out_valid, 0);
    chk("mrst_int_en", int_en, 0);   chk("mrst_comb_en", comb_en, 0);
    chk("mrst_overrun", overrun, 0); chk("mrst_y_out", y_out, 0);
    chk("mrst_out_count", out_count, 0);
    m_reset();
    run = 1'b0; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3 reset = 1'b1;
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
